// File: rtl/ctrl_unit_pkg.sv
// ctrl_unit_pkg: opcode/funct constants, control-field encodings, FSM state and
// instruction-class enums shared by the control unit and its decoder.
// OVF_EXCEPTION_EN adds the EXC state to the state enum.
package ctrl_unit_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ALUControl; PASS forwards operand A unchanged
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    // ShiftControl
    localparam logic [2:0] SH_HOLD = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;

    // PCSource
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;

    // ALUSrcB
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        ClsRAlu, ClsShift, ClsJr, ClsAddi, ClsLw, ClsSw, ClsBr, ClsJ, ClsIllegal
    } instr_cls_e;

    typedef enum logic [4:0] {
        StFetch, StDecode, StExecR, StWbR, StShLoad, StShOp, StWbSh, StExecJr,
        StExecI, StWbI, StAddr, StMemRd, StWbLw, StMemWr, StBranch, StJump
`ifdef OVF_EXCEPTION_EN
        , StExc
`endif
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic [1:0] pcsource;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       abwrite;
        logic       aluoutwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic [2:0] shiftctl;
        logic       regwrite;
        logic       regdest;
        logic       memtoreg;
        logic       writesrc;
        logic       epcwrite;
    } ctrl_t;

    // ALU operation for an R-type arithmetic funct
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // Shifter operation for an R-type shift funct
    function automatic logic [2:0] funct_shift_op(input logic [5:0] funct);
        case (funct)
            FN_SRL:  return SH_SRL;
            FN_SRA:  return SH_SRA;
            default: return SH_SLL;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if: instruction/flag inputs and every datapath control wire.
// master = control unit, slave = datapath.
interface ctrl_unit_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Overflow;
    logic       Igual;
    logic       PCwrite;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       ABWrite;
    logic       ALUOutWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ShiftControl;
    logic       RegWrite;
    logic       RegDest;
    logic       MemToReg;
    logic       WriteSrc;
    logic       EPCWrite;

    modport master (
        input  OPCODE, FUNCT, Overflow, Igual,
        output PCwrite, PCSource, IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite,
               ALUSrcA, ALUSrcB, ALUControl, ShiftControl, RegWrite, RegDest,
               MemToReg, WriteSrc, EPCWrite
    );

    modport slave (
        output OPCODE, FUNCT, Overflow, Igual,
        input  PCwrite, PCSource, IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite,
               ALUSrcA, ALUSrcB, ALUControl, ShiftControl, RegWrite, RegDest,
               MemToReg, WriteSrc, EPCWrite
    );
endinterface

// File: rtl/ctrl_unit_decode.sv
// ctrl_unit_decode: combinational OPCODE/FUNCT -> instruction class.
module ctrl_unit_decode
    import ctrl_unit_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output instr_cls_e cls_o
);

    // Classify the instruction; anything unrecognised becomes ClsIllegal (NOP)
    always_comb begin
        cls_o = ClsIllegal;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_SUB, FN_AND: cls_o = ClsRAlu;
                    FN_SLL, FN_SRL, FN_SRA: cls_o = ClsShift;
                    FN_JR:                  cls_o = ClsJr;
                    default:                cls_o = ClsIllegal;
                endcase
            end
            OP_ADDI:        cls_o = ClsAddi;
            OP_LW:          cls_o = ClsLw;
            OP_SW:          cls_o = ClsSw;
            OP_BEQ, OP_BNE: cls_o = ClsBr;
            OP_J:           cls_o = ClsJ;
            default:        cls_o = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multicycle main control FSM driving every cpu datapath control wire.
// Define OVF_EXCEPTION_EN to trap add/sub/addi overflow into a one-cycle EXC state.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    ctrl_unit_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             beq_q, beq_d, bne_q, bne_d;
    instr_cls_e       cls;

    ctrl_unit_decode u_decode (
        .opcode_i (bus.OPCODE),
        .funct_i  (bus.FUNCT),
        .cls_o    (cls)
    );

`ifndef OVF_EXCEPTION_EN
    // Overflow and the EPC path have no consumer in this build
    logic unused_ovf;
    assign unused_ovf = ^{bus.Overflow, ctrl_q.epcwrite};
`endif

    // Next state; the wait counter restarts on every state entry and saturates
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (cnt_q == WAIT_MAX) state_d = StDecode;
            StDecode: begin
                case (cls)
                    ClsRAlu:      state_d = StExecR;
                    ClsShift:     state_d = StShLoad;
                    ClsJr:        state_d = StExecJr;
                    ClsAddi:      state_d = StExecI;
                    ClsLw, ClsSw: state_d = StAddr;
                    ClsBr:        state_d = StBranch;
                    ClsJ:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            StExecR: begin
                state_d = StWbR;
`ifdef OVF_EXCEPTION_EN
                // and cannot overflow, so only add/sub trap
                if (bus.Overflow && bus.FUNCT != FN_AND) state_d = StExc;
`endif
            end
            StExecI: begin
                state_d = StWbI;
`ifdef OVF_EXCEPTION_EN
                if (bus.Overflow) state_d = StExc;
`endif
            end
            StShLoad: state_d = StShOp;
            StShOp:   state_d = StWbSh;
            StAddr:   state_d = (cls == ClsLw) ? StMemRd : StMemWr;
            StMemRd:  if (cnt_q == WAIT_MAX) state_d = StWbLw;
            default:  state_d = StFetch;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == WAIT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Moore outputs of the state being entered, so they register in step with it
    always_comb begin
        ctrl_d = '0;
        beq_d  = 1'b0;
        bne_d  = 1'b0;
        case (state_d)
            StFetch: begin
                ctrl_d.alusrcb = SRCB_FOUR;
                ctrl_d.aluctl  = ALU_ADD;
                if (cnt_d == WAIT_MAX) begin
                    ctrl_d.irwrite  = 1'b1;
                    ctrl_d.pcwrite  = 1'b1;
                    ctrl_d.pcsource = PCS_ALU;
                end
            end
            StDecode: begin
                ctrl_d.abwrite     = 1'b1;
                ctrl_d.aluoutwrite = 1'b1;
                ctrl_d.alusrcb     = SRCB_IMM_SH;
                ctrl_d.aluctl      = ALU_ADD;
            end
            StExecR: begin
                ctrl_d.alusrca     = 1'b1;
                ctrl_d.alusrcb     = SRCB_B;
                ctrl_d.aluctl      = funct_alu_op(bus.FUNCT);
                ctrl_d.aluoutwrite = 1'b1;
            end
            StExecI, StAddr: begin
                ctrl_d.alusrca     = 1'b1;
                ctrl_d.alusrcb     = SRCB_IMM;
                ctrl_d.aluctl      = ALU_ADD;
                ctrl_d.aluoutwrite = 1'b1;
            end
            StWbR: begin
                ctrl_d.regdest  = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            StWbI:    ctrl_d.regwrite = 1'b1;
            StShLoad: ctrl_d.shiftctl = SH_LOAD;
            StShOp:   ctrl_d.shiftctl = funct_shift_op(bus.FUNCT);
            StWbSh: begin
                ctrl_d.writesrc = 1'b1;
                ctrl_d.regdest  = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            StExecJr: begin
                ctrl_d.alusrca  = 1'b1;
                ctrl_d.aluctl   = ALU_PASS;
                ctrl_d.pcsource = PCS_ALU;
                ctrl_d.pcwrite  = 1'b1;
            end
            StMemRd: ctrl_d.iord = 1'b1;
            StMemWr: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            StWbLw: begin
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            StBranch: begin
                ctrl_d.alusrca  = 1'b1;
                ctrl_d.alusrcb  = SRCB_B;
                ctrl_d.aluctl   = ALU_CMP;
                ctrl_d.pcsource = PCS_ALUOUT;
                beq_d           = (bus.OPCODE == OP_BEQ);
                bne_d           = (bus.OPCODE == OP_BNE);
            end
            StJump: begin
                ctrl_d.pcsource = PCS_JUMP;
                ctrl_d.pcwrite  = 1'b1;
            end
`ifdef OVF_EXCEPTION_EN
            StExc: begin
                ctrl_d.epcwrite = 1'b1;
                ctrl_d.pcsource = PCS_EXC;
                ctrl_d.pcwrite  = 1'b1;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    // FSM state, wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            beq_q   <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            beq_q   <= beq_d;
            bne_q   <= bne_d;
        end
    end

    // Only the branch PC load looks at a live flag
    assign bus.PCwrite      = ctrl_q.pcwrite | (beq_q & bus.Igual) | (bne_q & ~bus.Igual);
    assign bus.PCSource     = ctrl_q.pcsource;
    assign bus.IorD         = ctrl_q.iord;
    assign bus.MemWrite     = ctrl_q.memwrite;
    assign bus.IRWrite      = ctrl_q.irwrite;
    assign bus.ABWrite      = ctrl_q.abwrite;
    assign bus.ALUOutWrite  = ctrl_q.aluoutwrite;
    assign bus.ALUSrcA      = ctrl_q.alusrca;
    assign bus.ALUSrcB      = ctrl_q.alusrcb;
    assign bus.ALUControl   = ctrl_q.aluctl;
    assign bus.ShiftControl = ctrl_q.shiftctl;
    assign bus.RegWrite     = ctrl_q.regwrite;
    assign bus.RegDest      = ctrl_q.regdest;
    assign bus.MemToReg     = ctrl_q.memtoreg;
    assign bus.WriteSrc     = ctrl_q.writesrc;
`ifdef OVF_EXCEPTION_EN
    assign bus.EPCWrite     = ctrl_q.epcwrite;
`else
    assign bus.EPCWrite     = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: directed bench for ctrl_unit with MEM_WAIT=2.
// Cycle 1 is the first cycle after reset release; outputs sampled on the falling edge.
module tb_ctrl_unit;
    import ctrl_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ctrl_unit_if bus ();

    ctrl_unit #(.MEM_WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic [1:0] pcs;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       abw;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [2:0] shc;
        logic       regw;
        logic       regd;
        logic       m2r;
        logic       wsrc;
        logic       epcw;
    } snap_t;

    snap_t lg [0:15];

    function automatic snap_t sample();
        snap_t s;
        s.pcw  = bus.PCwrite;
        s.pcs  = bus.PCSource;
        s.iord = bus.IorD;
        s.memw = bus.MemWrite;
        s.irw  = bus.IRWrite;
        s.abw  = bus.ABWrite;
        s.srca = bus.ALUSrcA;
        s.srcb = bus.ALUSrcB;
        s.aluc = bus.ALUControl;
        s.shc  = bus.ShiftControl;
        s.regw = bus.RegWrite;
        s.regd = bus.RegDest;
        s.m2r  = bus.MemToReg;
        s.wsrc = bus.WriteSrc;
        s.epcw = bus.EPCWrite;
        return s;
    endfunction

    // Record cycles 1..n into lg[1..n]; ends on the falling edge of cycle n+1
    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            lg[c] = sample();
            @(negedge clk);
        end
    endtask

    // Apply inputs, pulse reset, return at the falling edge of cycle 1
    task automatic do_reset(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                            input logic eq);
        bus.OPCODE   = op;
        bus.FUNCT    = fn;
        bus.Overflow = ov;
        bus.Igual    = eq;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.OPCODE   = OP_RTYPE;
        bus.FUNCT    = FN_ADD;
        bus.Overflow = 1'b0;
        bus.Igual    = 1'b1;
        reset        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h want 0", sample());
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        capture(2);
        checks++;
        if (lg[1] !== '0) begin
            errors++;
            $display("FAIL reset_cycle1 got %h want 0", lg[1]);
        end
        checks++;
        if (lg[2].srcb !== SRCB_FOUR || lg[2].aluc !== ALU_ADD || lg[2].irw !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle2_fetch got srcb %0h aluc %0h irw %0b want 1 1 0",
                     lg[2].srcb, lg[2].aluc, lg[2].irw);
        end
    endtask

    task automatic test_r_add();
        do_reset(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        capture(7);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (lg[c].irw !== (c == 3) || lg[c].pcw !== (c == 3)) begin
                errors++;
                $display("FAIL add_fetch cycle %0d got irw %0b pcw %0b want %0b", c,
                         lg[c].irw, lg[c].pcw, c == 3);
            end
            checks++;
            if (lg[c].abw !== (c == 4)) begin
                errors++;
                $display("FAIL add_abwrite cycle %0d got %0b want %0b", c, lg[c].abw, c == 4);
            end
            checks++;
            if (lg[c].regw !== (c == 6)) begin
                errors++;
                $display("FAIL add_regwrite cycle %0d got %0b want %0b", c, lg[c].regw, c == 6);
            end
        end
        checks++;
        if (lg[4].srcb !== SRCB_IMM_SH || lg[4].aluc !== ALU_ADD) begin
            errors++;
            $display("FAIL add_decode_sel got srcb %0h aluc %0h want 3 1", lg[4].srcb, lg[4].aluc);
        end
        checks++;
        if (lg[5].srca !== 1'b1 || lg[5].srcb !== SRCB_B || lg[5].aluc !== ALU_ADD) begin
            errors++;
            $display("FAIL add_exec_sel got srca %0b srcb %0h aluc %0h want 1 0 1",
                     lg[5].srca, lg[5].srcb, lg[5].aluc);
        end
        checks++;
        if (lg[6].regd !== 1'b1 || lg[6].m2r !== 1'b0 || lg[6].wsrc !== 1'b0) begin
            errors++;
            $display("FAIL add_wb_sel got regd %0b m2r %0b wsrc %0b want 1 0 0",
                     lg[6].regd, lg[6].m2r, lg[6].wsrc);
        end
        checks++;
        if (lg[7].srcb !== SRCB_FOUR || lg[7].aluc !== ALU_ADD || lg[7].srca !== 1'b0) begin
            errors++;
            $display("FAIL add_next_fetch got srcb %0h aluc %0h srca %0b want 1 1 0",
                     lg[7].srcb, lg[7].aluc, lg[7].srca);
        end
    endtask

    task automatic test_r_sub_and();
        do_reset(OP_RTYPE, FN_SUB, 1'b0, 1'b0);
        capture(5);
        checks++;
        if (lg[5].aluc !== ALU_SUB) begin
            errors++;
            $display("FAIL sub_aluctl got %0h want 2", lg[5].aluc);
        end
        do_reset(OP_RTYPE, FN_AND, 1'b0, 1'b0);
        capture(5);
        checks++;
        if (lg[5].aluc !== ALU_AND) begin
            errors++;
            $display("FAIL and_aluctl got %0h want 3", lg[5].aluc);
        end
    endtask

    task automatic test_lw();
        do_reset(OP_LW, 6'h00, 1'b0, 1'b0);
        capture(10);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (lg[c].iord !== (c >= 6 && c <= 8)) begin
                errors++;
                $display("FAIL lw_iord cycle %0d got %0b want %0b", c, lg[c].iord,
                         c >= 6 && c <= 8);
            end
            checks++;
            if (lg[c].regw !== (c == 9)) begin
                errors++;
                $display("FAIL lw_regwrite cycle %0d got %0b want %0b", c, lg[c].regw, c == 9);
            end
        end
        checks++;
        if (lg[9].m2r !== 1'b1 || lg[9].regd !== 1'b0) begin
            errors++;
            $display("FAIL lw_wb_sel got m2r %0b regd %0b want 1 0", lg[9].m2r, lg[9].regd);
        end
        checks++;
        if (lg[5].srca !== 1'b1 || lg[5].srcb !== SRCB_IMM) begin
            errors++;
            $display("FAIL lw_addr_sel got srca %0b srcb %0h want 1 2", lg[5].srca, lg[5].srcb);
        end
    endtask

    task automatic test_sw();
        do_reset(OP_SW, 6'h00, 1'b0, 1'b0);
        capture(8);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (lg[c].memw !== (c == 6) || lg[c].regw !== 1'b0) begin
                errors++;
                $display("FAIL sw_memwrite cycle %0d got memw %0b regw %0b want %0b 0", c,
                         lg[c].memw, lg[c].regw, c == 6);
            end
        end
        checks++;
        if (lg[6].iord !== 1'b1 || lg[7].srcb !== SRCB_FOUR) begin
            errors++;
            $display("FAIL sw_iord_next got iord %0b srcb %0h want 1 1", lg[6].iord, lg[7].srcb);
        end
    endtask

    task automatic test_branch();
        do_reset(OP_BEQ, 6'h00, 1'b0, 1'b0);
        capture(6);
        checks++;
        if (lg[5].pcw !== 1'b0 || lg[5].aluc !== ALU_CMP) begin
            errors++;
            $display("FAIL beq_not_taken got pcw %0b aluc %0h want 0 7", lg[5].pcw, lg[5].aluc);
        end
        do_reset(OP_BEQ, 6'h00, 1'b0, 1'b1);
        capture(6);
        checks++;
        if (lg[5].pcw !== 1'b1 || lg[5].pcs !== PCS_ALUOUT) begin
            errors++;
            $display("FAIL beq_taken got pcw %0b pcs %0h want 1 1", lg[5].pcw, lg[5].pcs);
        end
        checks++;
        if (lg[6].pcw !== 1'b0 || lg[6].srcb !== SRCB_FOUR) begin
            errors++;
            $display("FAIL beq_next_fetch got pcw %0b srcb %0h want 0 1", lg[6].pcw, lg[6].srcb);
        end
        do_reset(OP_BNE, 6'h00, 1'b0, 1'b0);
        capture(5);
        checks++;
        if (lg[5].pcw !== 1'b1 || lg[5].pcs !== PCS_ALUOUT) begin
            errors++;
            $display("FAIL bne_taken got pcw %0b pcs %0h want 1 1", lg[5].pcw, lg[5].pcs);
        end
        do_reset(OP_BNE, 6'h00, 1'b0, 1'b1);
        capture(5);
        checks++;
        if (lg[5].pcw !== 1'b0) begin
            errors++;
            $display("FAIL bne_not_taken got pcw %0b want 0", lg[5].pcw);
        end
    endtask

    task automatic test_jump();
        do_reset(OP_J, 6'h00, 1'b0, 1'b0);
        capture(6);
        checks++;
        if (lg[5].pcw !== 1'b1 || lg[5].pcs !== PCS_JUMP || lg[6].srcb !== SRCB_FOUR) begin
            errors++;
            $display("FAIL j_target got pcw %0b pcs %0h next srcb %0h want 1 2 1",
                     lg[5].pcw, lg[5].pcs, lg[6].srcb);
        end
        do_reset(OP_RTYPE, FN_JR, 1'b0, 1'b0);
        capture(6);
        checks++;
        if (lg[5].pcw !== 1'b1 || lg[5].pcs !== PCS_ALU || lg[5].srca !== 1'b1 ||
            lg[5].aluc !== ALU_PASS || lg[6].regw !== 1'b0) begin
            errors++;
            $display("FAIL jr_target got pcw %0b pcs %0h srca %0b aluc %0h want 1 0 1 0",
                     lg[5].pcw, lg[5].pcs, lg[5].srca, lg[5].aluc);
        end
    endtask

    task automatic test_shift();
        do_reset(OP_RTYPE, FN_SRA, 1'b0, 1'b0);
        capture(8);
        checks++;
        if (lg[5].shc !== SH_LOAD || lg[6].shc !== SH_SRA) begin
            errors++;
            $display("FAIL sra_shift got %0h %0h want 1 4", lg[5].shc, lg[6].shc);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (lg[c].regw !== (c == 7)) begin
                errors++;
                $display("FAIL sra_regwrite cycle %0d got %0b want %0b", c, lg[c].regw, c == 7);
            end
        end
        checks++;
        if (lg[7].wsrc !== 1'b1 || lg[7].regd !== 1'b1) begin
            errors++;
            $display("FAIL sra_wb_sel got wsrc %0b regd %0b want 1 1", lg[7].wsrc, lg[7].regd);
        end
        do_reset(OP_RTYPE, FN_SRL, 1'b0, 1'b0);
        capture(6);
        checks++;
        if (lg[6].shc !== SH_SRL) begin
            errors++;
            $display("FAIL srl_shift got %0h want 3", lg[6].shc);
        end
    endtask

    task automatic test_addi_ovf();
        do_reset(OP_ADDI, 6'h00, 1'b1, 1'b0);
        capture(8);
        checks++;
        if (lg[5].srca !== 1'b1 || lg[5].srcb !== SRCB_IMM || lg[5].aluc !== ALU_ADD) begin
            errors++;
            $display("FAIL addi_exec_sel got srca %0b srcb %0h aluc %0h want 1 2 1",
                     lg[5].srca, lg[5].srcb, lg[5].aluc);
        end
`ifdef OVF_EXCEPTION_EN
        checks++;
        if (lg[6].epcw !== 1'b1 || lg[6].pcs !== PCS_EXC || lg[6].pcw !== 1'b1) begin
            errors++;
            $display("FAIL addi_exc got epcw %0b pcs %0h pcw %0b want 1 3 1",
                     lg[6].epcw, lg[6].pcs, lg[6].pcw);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (lg[c].regw !== 1'b0) begin
                errors++;
                $display("FAIL addi_exc_regwrite cycle %0d got %0b want 0", c, lg[c].regw);
            end
        end
`else
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (lg[c].regw !== (c == 6) || lg[c].epcw !== 1'b0) begin
                errors++;
                $display("FAIL addi_regwrite cycle %0d got regw %0b epcw %0b want %0b 0", c,
                         lg[c].regw, lg[c].epcw, c == 6);
            end
        end
        checks++;
        if (lg[6].regd !== 1'b0) begin
            errors++;
            $display("FAIL addi_regdest got %0b want 0", lg[6].regd);
        end
`endif
    endtask

    task automatic test_illegal();
        do_reset(6'h3F, 6'h00, 1'b0, 1'b0);
        capture(8);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (lg[c].regw !== 1'b0 || lg[c].memw !== 1'b0 || lg[c].irw !== (c == 3 || c == 7)) begin
                errors++;
                $display("FAIL illegal_nop cycle %0d got regw %0b memw %0b irw %0b", c,
                         lg[c].regw, lg[c].memw, lg[c].irw);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(OP_LW, 6'h00, 1'b0, 1'b0);
        capture(7);
        // now in the last MEM_RD cycle; WB_LW would follow
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", sample());
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        capture(6);
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (lg[c].irw !== (c == 3) || lg[c].regw !== 1'b0) begin
                errors++;
                $display("FAIL midreset_refetch cycle %0d got irw %0b regw %0b want %0b 0", c,
                         lg[c].irw, lg[c].regw, c == 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        capture(13);
        for (int c = 1; c <= 13; c++) begin
            checks++;
            if (lg[c].regw !== (c == 6 || c == 12) || lg[c].irw !== (c == 3 || c == 9)) begin
                errors++;
                $display("FAIL b2b cycle %0d got regw %0b irw %0b", c, lg[c].regw, lg[c].irw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_r_sub_and();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_shift();
        test_addi_ovf();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
